// File: rtl/io_bridge_pkg.sv
// Shared address map, timer state encoding and CTRL bit positions for io_bridge.
package io_bridge_pkg;

    localparam logic [31:0] DM_LIMIT = 32'h0000_3000;
    localparam logic [31:0] DEV_BASE = 32'h0000_7F00;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESET   = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_IN_DATA  = 8'h10;
    localparam logic [7:0] OFF_IN_STAT  = 8'h14;
    localparam logic [7:0] OFF_OUT_DATA = 8'h20;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_MODE = 1;
    localparam int unsigned CTRL_IM   = 3;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_CNT  = 2'd2,
        T_INT  = 2'd3
    } timer_state_t;

    // Word-aligned offset inside the device window.
    function automatic logic [7:0] dev_offset(input logic [31:0] addr);
        return {addr[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU data-memory port bundle between the core (master) and the bridge (slave).
interface io_bridge_if;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;

    modport master (output cpu_addr, output cpu_we, output cpu_wdata, input cpu_rdata);
    modport slave  (input cpu_addr, input cpu_we, input cpu_wdata, output cpu_rdata);
endinterface

// File: rtl/io_bridge_timer_dev.sv
// Countdown timer device: CTRL/PRESET/COUNT registers, timer FSM and irq.
module timer_dev
    import io_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic         en;
    logic         mode;
    logic         im;
    logic         ctrl_wr;
    logic [31:0]  preset;
    logic [31:0]  count;
    timer_state_t state;

    logic ctrl_we;
    logic preset_we;

    assign ctrl_we   = we && (offset == OFF_CTRL);
    assign preset_we = we && (offset == OFF_PRESET);

    // Register writes plus the FSM; ctrl_wr delays CTRL-write reactions by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            mode    <= 1'b0;
            im      <= 1'b0;
            ctrl_wr <= 1'b0;
            preset  <= '0;
            count   <= '0;
            state   <= T_IDLE;
        end else begin
            ctrl_wr <= ctrl_we;
            if (ctrl_we) begin
                en   <= wdata[CTRL_EN];
                mode <= wdata[CTRL_MODE];
                im   <= wdata[CTRL_IM];
            end
            if (preset_we) begin
                preset <= wdata;
            end
            if (ctrl_wr && !en) begin
                state <= T_IDLE;
            end else begin
                case (state)
                    T_IDLE: if (en) state <= T_LOAD;
                    T_LOAD: begin
                        count <= preset;
                        state <= (preset == '0) ? T_INT : T_CNT;
                    end
                    T_CNT: begin
                        if (count <= 32'd1) begin
                            count <= '0;
                            state <= T_INT;
                        end else begin
                            count <= count - 32'd1;
                        end
                    end
                    T_INT: if (mode || ctrl_wr) state <= T_LOAD;
                    default: state <= T_IDLE;
                endcase
            end
        end
    end

    assign irq = (state == T_INT) && im;

    // Register read mux.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL: begin
                rdata[CTRL_EN]   = en;
                rdata[CTRL_MODE] = mode;
                rdata[CTRL_IM]   = im;
            end
            OFF_PRESET: rdata = preset;
            OFF_COUNT:  rdata = count;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped bridge: decodes CPU accesses to data memory, input sampler,
// output register and countdown timer.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    io_bridge_if.slave  bus,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] input_data,
    output logic [31:0] output_data,
    output logic        irq
);

    logic        dm_sel;
    logic        dev_sel;
    logic [7:0]  offset;
    logic        dev_we;
    logic [31:0] timer_rdata;

    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] in_prev;
    logic        chg;
    logic        chg_set;
    logic        chg_clr;

    assign dm_sel  = bus.cpu_addr < DM_LIMIT;
    assign dev_sel = bus.cpu_addr[31:8] == DEV_BASE[31:8];
    assign offset  = dev_offset(bus.cpu_addr);
    assign dev_we  = bus.cpu_we && dev_sel;

    assign dm_addr  = bus.cpu_addr;
    assign dm_wdata = bus.cpu_wdata;
    assign dm_we    = bus.cpu_we && dm_sel;

    assign chg_set = sync_q[SYNC_STAGES-1] != in_prev;
    assign chg_clr = dev_we && (offset == OFF_IN_STAT) && bus.cpu_wdata[0];

    // Input synchroniser chain and change flag; a new change beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            in_prev <= '0;
            chg     <= 1'b0;
        end else begin
            sync_q[0] <= input_data;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            in_prev <= sync_q[SYNC_STAGES-1];
            chg     <= chg_set || (chg && !chg_clr);
        end
    end

    // Output device register, updated on the store edge itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_data <= '0;
        end else if (dev_we && (offset == OFF_OUT_DATA)) begin
            output_data <= bus.cpu_wdata;
        end
    end

    timer_dev u_timer (
        .clk    (clk),
        .rst    (rst),
        .we     (dev_we),
        .offset (offset),
        .wdata  (bus.cpu_wdata),
        .rdata  (timer_rdata),
        .irq    (irq)
    );

    // Same-cycle load data: DM, device window, or zero for unmapped space.
    always_comb begin
        bus.cpu_rdata = '0;
        if (dm_sel) begin
            bus.cpu_rdata = dm_rdata;
        end else if (dev_sel) begin
            case (offset)
                OFF_CTRL, OFF_PRESET, OFF_COUNT: bus.cpu_rdata = timer_rdata;
                OFF_IN_DATA:  bus.cpu_rdata = sync_q[SYNC_STAGES-1];
                OFF_IN_STAT:  bus.cpu_rdata = {31'd0, chg};
                OFF_OUT_DATA: bus.cpu_rdata = output_data;
                default:      bus.cpu_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: timestamp-based reference model checked
// every falling edge, plus hand-computed directed expectations.
module tb_io_bridge;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [31:0] input_data;
    logic [31:0] output_data;
    logic        irq;

    io_bridge_if bus ();

    io_bridge #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dm_addr     (dm_addr),
        .dm_we       (dm_we),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .input_data  (input_data),
        .output_data (output_data),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Timer is described by timestamps: COUNT gets value P at
    // edge L, then counts down one per edge; expiry is edge L+P.
    logic [31:0] m_out, m_preset;
    logic        m_en, m_mode, m_im, m_chg;
    logic [31:0] m_q[$];
    logic [31:0] m_count, held;
    bit          m_int, run, pend_stop, model_ok;
    int          k, L, P, pend_edge;

    function automatic logic [31:0] exp_rdata();
        logic [31:0] a;
        a = bus.cpu_addr;
        if (a < 32'h3000) return dm_rdata;
        if (a[31:8] != 24'h00007F) return 32'd0;
        case (a[7:0] & 8'hFC)
            8'h00:   return {28'd0, m_im, 1'b0, m_mode, m_en};
            8'h04:   return m_preset;
            8'h08:   return m_count;
            8'h10:   return m_q[SYNC-1];
            8'h14:   return {31'd0, m_chg};
            8'h20:   return m_out;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        logic [31:0] a, d, preset_before;
        logic [7:0]  off;
        bit          wr_dev, set;
        int          diff;
        a      = bus.cpu_addr;
        d      = bus.cpu_wdata;
        off    = a[7:0] & 8'hFC;
        wr_dev = bus.cpu_we && (a[31:8] == 24'h00007F);
        if (rst) begin
            m_out = 0; m_preset = 0; m_en = 0; m_mode = 0; m_im = 0; m_chg = 0;
            m_q = {};
            for (int i = 0; i <= SYNC; i++) m_q.push_back(32'd0);
            m_count = 0; held = 0; m_int = 0; run = 0; pend_stop = 0;
            k = 0; L = 0; P = 0; pend_edge = -1;
            model_ok = 1;
            return;
        end
        k++;
        // input delay line and change flag
        set = m_q[SYNC-1] != m_q[SYNC];
        m_q.push_front(input_data);
        void'(m_q.pop_back());
        m_chg = set || (m_chg && !(wr_dev && off == 8'h14 && d[0]));
        // timer
        preset_before = m_preset;
        if (pend_edge == k) begin
            held = m_count;
            if (pend_stop) run = 0;
            else begin run = 1; L = k + 1; end
            pend_edge = -1;
        end
        if (run && m_mode && k == L + P + 2) L = k;
        if (run && k == L) P = int'(preset_before);
        if (!run || k < L) begin
            m_count = held;
            m_int = 0;
        end else begin
            diff = k - L;
            m_count = (P > diff) ? 32'(P - diff) : 32'd0;
            m_int = (k >= L + P) && (!m_mode || k == L + P);
        end
        // register writes
        if (wr_dev) begin
            case (off)
                8'h00: begin
                    if (!d[0]) begin pend_edge = k + 1; pend_stop = 1; end
                    else if (!run || (!m_mode && m_int)) begin pend_edge = k + 1; pend_stop = 0; end
                    m_en = d[0]; m_mode = d[1]; m_im = d[3];
                end
                8'h04: m_preset = d;
                8'h20: m_out = d;
                default: ;
            endcase
        end
    endtask

    // Compare DUT against the model, then advance the model with the inputs
    // the next rising edge will see.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("output_data", output_data, m_out);
            chk("irq", {31'd0, irq}, {31'd0, m_int && m_im});
            chk("dm_we", {31'd0, dm_we}, {31'd0, bus.cpu_we && (bus.cpu_addr < 32'h3000)});
            chk("dm_addr", dm_addr, bus.cpu_addr);
            chk("dm_wdata", dm_wdata, bus.cpu_wdata);
            chk("cpu_rdata", bus.cpu_rdata, exp_rdata());
        end
        step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_addr  = a;
        bus.cpu_we    = 1'b1;
        bus.cpu_wdata = d;
        tick();
        bus.cpu_we    = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.cpu_addr = a;
        #1;
        chk(name, bus.cpu_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        bus.cpu_addr  = 32'd0;
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = 32'd0;
        input_data    = 32'd0;
        dm_rdata      = 32'h1357_9BDF;
        rst           = 1'b1;

        // reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_out", output_data, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd("rst_count", 32'h7F08, 32'd0);
        rd("rst_in_data", 32'h7F10, 32'd0);
        rd("rst_in_stat", 32'h7F14, 32'd0);

        // output store
        tick();
        bus.cpu_addr = 32'h7F20; bus.cpu_we = 1'b1; bus.cpu_wdata = 32'hDEAD_BEEF;
        #1;
        chk("out_dm_we", {31'd0, dm_we}, 32'd0);
        tick();
        bus.cpu_we = 1'b0;
        chk("out_data", output_data, 32'hDEAD_BEEF);
        rd("out_readback", 32'h7F20, 32'hDEAD_BEEF);

        // input sampler
        input_data = 32'h1234_5678;
        tick();
        rd("in_e1", 32'h7F10, 32'd0);
        tick();
        rd("in_e2", 32'h7F10, 32'h1234_5678);
        rd("chg_e2", 32'h7F14, 32'd0);
        tick();
        rd("chg_e3", 32'h7F14, 32'd1);
        wr(32'h7F14, 32'd1);
        rd("chg_clr", 32'h7F14, 32'd0);
        input_data = 32'h1234_5678;
        tick(); tick(); tick();
        rd("chg_same", 32'h7F14, 32'd0);
        input_data = 32'h1111_1111;
        tick(); tick(); tick();
        rd("chg_new", 32'h7F14, 32'd1);
        rd("in_new", 32'h7F10, 32'h1111_1111);
        wr(32'h7F14, 32'd1);
        rd("chg_clr2", 32'h7F14, 32'd0);

        // DM path, boundary and unmapped space
        bus.cpu_addr = 32'h10; bus.cpu_we = 1'b1; bus.cpu_wdata = 32'hA5A5_A5A5;
        #1;
        chk("dm_we_st", {31'd0, dm_we}, 32'd1);
        chk("dm_addr_st", dm_addr, 32'h10);
        chk("dm_wdata_st", dm_wdata, 32'hA5A5_A5A5);
        tick();
        bus.cpu_we = 1'b0;
        rd("dm_rd", 32'h10, 32'h1357_9BDF);
        rd("dm_last", 32'h2FFC, 32'h1357_9BDF);
        rd("dm_limit", 32'h3000, 32'd0);
        tick();
        rd("unmapped_rd", 32'h5000, 32'd0);
        bus.cpu_we = 1'b1; bus.cpu_wdata = 32'h0000_0055;
        #1;
        chk("unmapped_dm_we", {31'd0, dm_we}, 32'd0);
        tick();
        bus.cpu_we = 1'b0;
        chk("unmapped_out", output_data, 32'hDEAD_BEEF);
        rd("unmapped_ctrl", 32'h7F00, 32'd0);

        // one-shot timer
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);               // E0
        bus.cpu_addr = 32'h7F08;
        tick(); tick();                     // E2
        rd("os_count_e2", 32'h7F08, 32'd5);
        tick(); tick(); tick(); tick();     // E6
        rd("os_count_e6", 32'h7F08, 32'd1);
        chk("os_irq_e6", {31'd0, irq}, 32'd0);
        tick();                             // E7
        rd("os_count_e7", 32'h7F08, 32'd0);
        chk("os_irq_e7", {31'd0, irq}, 32'd1);
        tick(); tick(); tick();
        chk("os_irq_hold", {31'd0, irq}, 32'd1);
        rd("os_ctrl", 32'h7F00, 32'h9);
        wr(32'h7F00, 32'h0);
        chk("os_irq_off", {31'd0, irq}, 32'd0);
        tick();
        chk("os_irq_off2", {31'd0, irq}, 32'd0);
        rd("os_count_hold", 32'h7F08, 32'd0);

        // auto-reload timer
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'hB);                // E0
        bus.cpu_addr = 32'h7F08;
        pat = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat[i] = irq;
        end
        chk("ar_irq_pattern", {24'd0, pat}, 32'h88);
        wr(32'h7F04, 32'd0);                // E9
        tick();                             // E10
        chk("ar_p0_irq", {31'd0, irq}, 32'd1);
        rd("ar_p0_count", 32'h7F08, 32'd0);
        wr(32'h7F04, 32'd7);                // E11
        tick(); tick(); tick();             // E14
        rd("ar_count7", 32'h7F08, 32'd5);

        // reset mid-count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        chk("rst_mid_out", output_data, 32'd0);
        rd("rst_mid_count", 32'h7F08, 32'd0);
        rd("rst_mid_ctrl", 32'h7F00, 32'd0);
        tick(); tick();
        rd("rst_mid_idle", 32'h7F08, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory-mapped system bridge between the MIPS core's data-memory port and the board-level devices in `top`. It sits directly between `my_mips` and the data memory plus the `input_data`/`output_data` pins.
- Decodes each CPU load/store address to one of four targets: data memory, the input-device sampler, the output-device register, or a countdown timer.
- The input sampler raises a change flag when `input_data` changes. The timer raises `irq` on expiry.

Parameters:
- DM_LIMIT, 32'h0000_3000, first byte address not mapped to data memory.
- DEV_BASE, 32'h0000_7F00, base of the 256-byte device window.
- SYNC_STAGES, 2, synchroniser depth on `input_data`; legal range is 2..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  32  byte address from the core; bits [1:0] are ignored.
- cpu_we  in  1  store strobe.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; combinational, available in the same cycle.
- dm_addr  out  32  pass-through of `cpu_addr`.
- dm_we  out  1  `cpu_we` gated by the DM decode.
- dm_wdata  out  32  pass-through of `cpu_wdata`.
- dm_rdata  in  32  data-memory read data.
- input_data  in  32  external input device; asynchronous to `clk`.
- output_data  out  32  external output device register.
- irq  out  1  timer interrupt to the core.

Behaviour:
- Reset: one `clk` edge with `rst`=1 clears every register. Values after reset:
  - `output_data`=0, `irq`=0.
  - Sampler registers=0, including the synchroniser stages and the change flag.
  - Timer CTRL=0, PRESET=0, COUNT=0, state=IDLE.
  - `rst` asserted mid-count aborts the count immediately.
- Address decode:
  - `cpu_addr`<DM_LIMIT selects DM.
  - `cpu_addr`[31:8]==DEV_BASE[31:8] selects the device window.
  - Any other address: reads return 0 and writes are dropped.
  - `dm_we` is asserted only when DM is selected.
- Device map, offsets within the window:
  - 0x00 CTRL (rw): bit0 EN, bit1 MODE (0 = one-shot, 1 = auto-reload), bit3 IM; other bits read 0.
  - 0x04 PRESET (rw).
  - 0x08 COUNT (ro).
  - 0x10 IN_DATA (ro): the synchronised `input_data`.
  - 0x14 IN_STAT (bit0 CHG): write 1 to clear.
  - 0x20 OUT_DATA (rw): drives `output_data`.
  - Unlisted offsets read 0; writes to them and to read-only offsets are ignored.
- Write timing: all writes take effect at the `clk` edge on which `cpu_we`=1. `output_data` changes at that edge, with no additional latency.
- Input sampler:
  - `input_data` passes through SYNC_STAGES flops; IN_DATA is the last stage.
  - CHG is set when the last stage differs from its previous value.
  - If a set and a write-1-clear occur in the same cycle, set wins.
  - With SYNC_STAGES=2, a change on `input_data` shows in IN_DATA after 2 edges and in CHG after 3 edges.
- Timer FSM, states IDLE, LOAD, CNT, INT:
  - IDLE→LOAD on the edge after CTRL is written with EN=1.
  - LOAD: COUNT←PRESET, then →CNT. If PRESET==0, →INT instead.
  - CNT: COUNT decrements each edge; on the edge where COUNT goes 1→0, →INT.
  - INT, MODE=0: holds until CTRL is written, then re-evaluates EN.
  - INT, MODE=1: lasts exactly 1 cycle, then →LOAD.
  - Writing CTRL with EN=0 in any state gives →IDLE on the next edge; COUNT holds its value.
  - A PRESET write during CNT does not affect the current count; it is used at the next LOAD.
  - COUNT never wraps below 0.
- `irq` = (state==INT) & IM. It is registered via the state register and is glitch-free.

Decomposition:
- Shared package:
  - Address constants: DM_LIMIT, DEV_BASE, and the offsets CTRL, PRESET, COUNT, IN_DATA, IN_STAT, OUT_DATA.
  - Timer state encoding, 2 bits.
  - CTRL bit positions.
- One sub-module, `timer_dev`:
  - Owns CTRL, PRESET, COUNT, the FSM and `irq`.
  - Receives `we`, `offset` and `wdata`; returns `rdata`.
- The sampler and OUT_DATA stay inline in `io_bridge`.

Test Plan:
- Reset: hold `rst` for 2 cycles → `output_data`=0, `irq`=0, and reads of 0x7F08, 0x7F10 and 0x7F14 all return 0.
- Output store: store 0xDEADBEEF to 0x7F20 → `output_data`=0xDEADBEEF after that edge, `dm_we` stays 0, and a load of 0x7F20 returns 0xDEADBEEF.
- Input change: `input_data` 0→0x12345678 → 0x7F10 reads 0x12345678 after 2 edges and 0x7F14 reads 1 after 3 edges. Then store 1 to 0x7F14 → reads 0. Re-drive 0x12345678 (unchanged) → CHG stays 0. Then drive 0x11111111 → CHG=1.
- DM path and unmapped: store 0xA5A5A5A5 to 0x0000_0010 → `dm_we`=1 with `dm_addr`=0x10. A load of 0x0000_5000 returns 0 and produces no writes anywhere.
- Timer one-shot: PRESET=5, then CTRL=0x9 (EN, IM) written at edge E0 → COUNT=5 at E2, COUNT=0 and `irq`=1 at E7. `irq` holds until CTRL is written with 0, then drops on the next edge.
- Timer auto-reload and reset abort:
  - PRESET=2, CTRL=0xB → `irq` pulses for 1 cycle every 4 cycles.
  - A PRESET=0 load goes straight to INT.
  - Asserting `rst` mid-count → COUNT=0 and `irq`=0 after the edge.
